// File: rtl/icg_pkg.sv
// Shared types and width helpers for the activity-driven clock-enable controller.
package icg_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        WAKE = 2'd1,
        ON   = 2'd2,
        HOLD = 2'd3
    } icg_state_t;

    localparam int DEF_HOLD_CYCLES = 8;
    localparam int DEF_WAKE_CYCLES = 1;
    localparam int DEF_CNT_W       = 16;

    // Bits needed to hold n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_HOLD_W = cnt_width(DEF_HOLD_CYCLES);
    localparam int DEF_WAKE_W = cnt_width(DEF_WAKE_CYCLES);

endpackage

// File: rtl/icg_enable_ctrl_if.sv
// Activity request / enable status bundle between the requester and the enable controller.
interface icg_enable_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             act;
    logic             force_on;
    logic             cnt_clr;
    logic             en;
    logic             rdy;
    logic [CNT_W-1:0] gated_cnt;

    modport master (
        output act, force_on, cnt_clr,
        input  en, rdy, gated_cnt
    );

    modport slave (
        input  act, force_on, cnt_clr,
        output en, rdy, gated_cnt
    );
endinterface

// File: rtl/icg_sat_counter.sv
// Saturating up-counter with synchronous clear that takes priority over increment.
module icg_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_r;

    // Count register: clear first, then increment unless already saturated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (inc && (count_r != {CNT_W{1'b1}})) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/icg_enable_ctrl.sv
// Converts bursty activity into a registered clock enable with wake-up delay and idle hold-off.
module icg_enable_ctrl
    import icg_pkg::*;
#(
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int WAKE_CYCLES = DEF_WAKE_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    icg_enable_ctrl_if.slave  bus
);

    localparam int HW = cnt_width(HOLD_CYCLES);
    localparam int WW = cnt_width(WAKE_CYCLES);
    localparam logic [HW-1:0] HOLD_LOAD = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [WW-1:0] WAKE_LOAD = WW'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);

    icg_state_t       state_r;
    icg_state_t       next_s;
    logic [WW-1:0]    wake_cnt_r;
    logic [HW-1:0]    hold_cnt_r;
    logic             en_r;
    logic             rdy_r;
    logic             wake_s;
    logic             off_s;
    logic [CNT_W-1:0] cnt_s;

    assign wake_s = bus.act | bus.force_on;
    assign off_s  = (state_r == OFF);

    // Next-state selection; the wake phase runs to completion regardless of activity.
    always_comb begin
        next_s = state_r;
        case (state_r)
            OFF: begin
                if (wake_s) begin
                    next_s = (WAKE_CYCLES == 0) ? ON : WAKE;
                end else begin
                    next_s = OFF;
                end
            end
            WAKE: begin
                if (wake_cnt_r == '0) begin
                    next_s = ON;
                end else begin
                    next_s = WAKE;
                end
            end
            ON: begin
                if (wake_s) begin
                    next_s = ON;
                end else begin
                    next_s = (HOLD_CYCLES == 0) ? OFF : HOLD;
                end
            end
            HOLD: begin
                if (wake_s) begin
                    next_s = ON;
                end else if (hold_cnt_r == '0) begin
                    next_s = OFF;
                end else begin
                    next_s = HOLD;
                end
            end
            default: next_s = OFF;
        endcase
    end

    // State, counters and outputs; en/rdy decode the next state so they settle just after the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= OFF;
            wake_cnt_r <= '0;
            hold_cnt_r <= '0;
            en_r       <= 1'b0;
            rdy_r      <= 1'b0;
        end else begin
            state_r <= next_s;
            en_r    <= (next_s != OFF);
            rdy_r   <= (next_s == ON) || (next_s == HOLD);
            case (state_r)
                OFF: begin
                    if (wake_s) begin
                        wake_cnt_r <= WAKE_LOAD;
                    end
                end
                WAKE: begin
                    if (wake_cnt_r != '0) begin
                        wake_cnt_r <= wake_cnt_r - WW'(1);
                    end
                end
                ON: begin
                    if (!wake_s) begin
                        hold_cnt_r <= HOLD_LOAD;
                    end
                end
                HOLD: begin
                    if (!wake_s && (hold_cnt_r != '0)) begin
                        hold_cnt_r <= hold_cnt_r - HW'(1);
                    end
                end
                default: begin
                    wake_cnt_r <= '0;
                    hold_cnt_r <= '0;
                end
            endcase
        end
    end

    icg_sat_counter #(
        .CNT_W (CNT_W)
    ) u_gated_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (off_s),
        .clr   (bus.cnt_clr),
        .count (cnt_s)
    );

    assign bus.en        = en_r;
    assign bus.rdy       = rdy_r;
    assign bus.gated_cnt = cnt_s;

endmodule

// File: tb/tb_icg_enable_ctrl.sv
// Self-checking bench: three parameterisations driven in lockstep against a behavioural model.
module tb_icg_enable_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic act;
    logic force_on;
    logic cnt_clr;

    always #5 clk = ~clk;

    icg_enable_ctrl_if #(.CNT_W(16)) if_a ();
    icg_enable_ctrl_if #(.CNT_W(4))  if_b ();
    icg_enable_ctrl_if #(.CNT_W(8))  if_c ();

    assign if_a.act = act;  assign if_a.force_on = force_on;  assign if_a.cnt_clr = cnt_clr;
    assign if_b.act = act;  assign if_b.force_on = force_on;  assign if_b.cnt_clr = cnt_clr;
    assign if_c.act = act;  assign if_c.force_on = force_on;  assign if_c.cnt_clr = cnt_clr;

    icg_enable_ctrl #(.HOLD_CYCLES(8), .WAKE_CYCLES(1), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    icg_enable_ctrl #(.HOLD_CYCLES(0), .WAKE_CYCLES(0), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .bus(if_b));
    icg_enable_ctrl #(.HOLD_CYCLES(3), .WAKE_CYCLES(2), .CNT_W(8))  dut_c (.clk(clk), .rst(rst), .bus(if_c));

    int p_h  [3] = '{8, 0, 3};
    int p_w  [3] = '{1, 0, 2};
    int p_cw [3] = '{16, 4, 8};

    // Model: enable flag, edges since enable rose, consecutive idle edges once ready, count.
    int m_en [3];
    int m_rdy[3];
    int m_age[3];
    int m_idle[3];
    int m_cnt[3];

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic act;
        logic exp_en;
        logic exp_rdy;
    } vec_t;
    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] get_en(input int i);
        case (i)
            0:       return 32'(if_a.en);
            1:       return 32'(if_b.en);
            default: return 32'(if_c.en);
        endcase
    endfunction

    function automatic logic [31:0] get_rdy(input int i);
        case (i)
            0:       return 32'(if_a.rdy);
            1:       return 32'(if_b.rdy);
            default: return 32'(if_c.rdy);
        endcase
    endfunction

    function automatic logic [31:0] get_cnt(input int i);
        case (i)
            0:       return 32'(if_a.gated_cnt);
            1:       return 32'(if_b.gated_cnt);
            default: return 32'(if_c.gated_cnt);
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_en[i] = 0; m_rdy[i] = 0; m_age[i] = 0; m_idle[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic model_step();
        int wake;
        int was_off;
        int cmax;
        wake = (act || force_on) ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            was_off = (m_en[i] == 0) ? 1 : 0;
            cmax    = (1 << p_cw[i]) - 1;
            if (m_en[i] == 0) begin
                if (wake != 0) begin
                    m_en[i]   = 1;
                    m_age[i]  = 0;
                    m_rdy[i]  = (p_w[i] == 0) ? 1 : 0;
                    m_idle[i] = 0;
                end
            end else if (m_rdy[i] == 0) begin
                m_age[i]++;
                if (m_age[i] >= p_w[i]) m_rdy[i] = 1;
                m_idle[i] = 0;
            end else begin
                m_idle[i] = (wake != 0) ? 0 : m_idle[i] + 1;
                if (m_idle[i] > p_h[i]) begin
                    m_en[i]  = 0;
                    m_rdy[i] = 0;
                end
            end
            if (cnt_clr) m_cnt[i] = 0;
            else if (was_off != 0 && m_cnt[i] < cmax) m_cnt[i]++;
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("model%0d_en", i),  get_en(i),  32'(m_en[i]));
            check($sformatf("model%0d_rdy", i), get_rdy(i), 32'(m_rdy[i]));
            check($sformatf("model%0d_cnt", i), get_cnt(i), 32'(m_cnt[i]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic async_reset_check(input string tag);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_en%0d", tag, i),  get_en(i),  32'd0);
            check($sformatf("%s_rdy%0d", tag, i), get_rdy(i), 32'd0);
            check($sformatf("%s_cnt%0d", tag, i), get_cnt(i), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] snap;

        for (int i = 0; i < 16; i++) tbl[i] = '{1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b0};
        for (int i = 5; i <= 13; i++) tbl[i] = '{1'b0, 1'b1, 1'b1};

        rst = 1'b1; act = 1'b0; force_on = 1'b0; cnt_clr = 1'b0;
        model_reset();
        #12;
        compare_all();
        @(negedge clk);
        rst = 1'b0;

        // Idle count and saturation of the narrow counter.
        for (int k = 0; k < 20; k++) cycle();
        check("idle20_cnt_a", 32'(if_a.gated_cnt), 32'd20);
        check("idle20_sat_b", 32'(if_b.gated_cnt), 32'd15);
        check("idle20_en_a",  32'(if_a.en),        32'd0);
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        check("clr_wins_a", 32'(if_a.gated_cnt), 32'd0);
        check("clr_wins_b", 32'(if_b.gated_cnt), 32'd0);
        for (int k = 0; k < 5; k++) cycle();
        async_reset_check("rst_midcount");

        // Single act pulse through wake, on, hold and back to off.
        for (int i = 0; i < 16; i++) begin
            act = tbl[i].act;
            cycle();
            check($sformatf("tbl%0d_en", i),  32'(if_a.en),  32'(tbl[i].exp_en));
            check($sformatf("tbl%0d_rdy", i), 32'(if_a.rdy), 32'(tbl[i].exp_rdy));
        end

        // Re-pulse in the final hold cycle: no dropout, new window from that act.
        act = 1'b1;
        cycle();
        act = 1'b0;
        for (int k = 0; k < 9; k++) begin
            cycle();
            check("repulse_pre_en", 32'(if_a.en), 32'd1);
        end
        act = 1'b1;
        cycle();
        check("repulse_hit_en",  32'(if_a.en),  32'd1);
        check("repulse_hit_rdy", 32'(if_a.rdy), 32'd1);
        act = 1'b0;
        for (int k = 0; k < 9; k++) begin
            cycle();
            check($sformatf("repulse_hold%0d_en", k), 32'(if_a.en), (k < 8) ? 32'd1 : 32'd0);
        end

        // Zero wake / zero hold: one-edge rise and fall.
        act = 1'b1;
        cycle();
        check("z_rise_en",  32'(if_b.en),  32'd1);
        check("z_rise_rdy", 32'(if_b.rdy), 32'd1);
        act = 1'b0;
        cycle();
        check("z_fall_en",  32'(if_b.en),  32'd0);
        check("z_fall_rdy", 32'(if_b.rdy), 32'd0);

        // force_on keeps the domain clocked and freezes the off counter.
        for (int k = 0; k < 12; k++) cycle();
        force_on = 1'b1;
        cycle();
        snap = 32'(if_a.gated_cnt);
        for (int k = 0; k < 49; k++) begin
            cycle();
            check("force_en", 32'(if_a.en), 32'd1);
        end
        check("force_cnt_frozen", 32'(if_a.gated_cnt), snap);
        force_on = 1'b0;

        // Randomised bursts, overrides and clears.
        for (int k = 0; k < 800; k++) begin
            act      = ((k % 100) < 50) ? ($urandom_range(2, 0) == 0) : ($urandom_range(14, 0) == 0);
            force_on = ($urandom_range(59, 0) == 0);
            cnt_clr  = ($urandom_range(49, 0) == 0);
            cycle();
        end
        act = 1'b0; force_on = 1'b0; cnt_clr = 1'b0;

        // Reset while enabled drops outputs without a clock edge.
        act = 1'b1;
        cycle();
        cycle();
        check("pre_rst_en_a", 32'(if_a.en), 32'd1);
        async_reset_check("rst_active");
        act = 1'b0;
        for (int k = 0; k < 4; k++) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/icg_enable_ctrl.md
# icg_enable_ctrl

Activity-driven enable generator that sits directly upstream of the latch-based clock-gated D flip-flop bank and drives its `en` input. It converts bursty activity requests into a glitch-free, registered enable with wake-up delay and idle hold-off, so the gated clock does not toggle on and off every few cycles. It also reports when the gated domain may accept data, and keeps a saturating count of gated-off cycles for power profiling.

## Interface
Parameters:
- `HOLD_CYCLES`, 8: idle cycles during which `en` stays high after the last activity; 0 means drop `en` immediately.
- `WAKE_CYCLES`, 1: cycles with `en` high before `rdy` asserts; 0 means `rdy` asserts together with `en`.
- `CNT_W`, 16: width of the gated-cycle counter.

Ports:
- `clk`, in, 1: the single clock. All state is posedge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `act`, in, 1: activity request; the gated registers need clocking this cycle.
- `force_on`, in, 1: override that keeps `en` high and behaves like continuous `act`.
- `cnt_clr`, in, 1: synchronous clear of `gated_cnt`.
- `en`, out, 1: clock enable to the ICG. Always a flop output.
- `rdy`, out, 1: the gated domain is clocked and settled, so data may be presented.
- `gated_cnt`, out, CNT_W: saturating count of cycles spent in OFF.

## Operation
- Define `wake = act | force_on`.
- FSM states:
  - OFF: `en`=0, `rdy`=0.
  - WAKE: `en`=1, `rdy`=0.
  - ON: `en`=1, `rdy`=1.
  - HOLD: `en`=1, `rdy`=1.
- Reset state is OFF. On reset, `en`=0, `rdy`=0, `gated_cnt`=0, and the wake and hold counters are 0.
- OFF:
  - If `wake`, go to WAKE and load the wake counter with WAKE_CYCLES-1.
  - If `wake` and WAKE_CYCLES==0, go directly to ON.
- WAKE:
  - Decrement the wake counter each cycle. Go to ON when it is 0.
  - `wake` is ignored while in WAKE. Once the wake sequence starts, it completes even if `act` drops.
- ON:
  - If `wake`, stay in ON.
  - If not `wake`, go to HOLD and load the hold counter with HOLD_CYCLES-1.
  - If not `wake` and HOLD_CYCLES==0, go directly to OFF.
- HOLD:
  - If `wake`, go back to ON. The counter is reloaded on the next ON→HOLD transition.
  - Otherwise decrement the counter. Go to OFF when it is 0 and `wake` is low.
- `en` and `rdy` are registered decodes of the next state, so both change only just after a posedge.
- `gated_cnt`:
  - Increments in every cycle whose current state is OFF.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - When `cnt_clr` coincides with an increment, clear wins and the result is 0.

## Timing
- `act` sampled high at edge N from OFF:
  - `en` rises after edge N.
  - The first gated clock edge is N+1.
  - `rdy` rises after edge N+WAKE_CYCLES.
- `act` last high at edge M in ON:
  - `en` stays high through HOLD_CYCLES further edges.
  - `en` falls after edge M+HOLD_CYCLES+1, with `rdy` falling together with it.
- `act` re-asserted in the final HOLD cycle: stay in ON, with no `en` dropout.
- `force_on` held high: `en` never drops; the count of gated-off cycles stays frozen.
- `rst` asserted mid-operation: `en` and `rdy` drop to 0 immediately, without waiting for a clock edge. The FSM restarts from OFF after release. A truncated gated pulse during reset is acceptable.
- Latency from `wake` to `en` is exactly 1 edge. There is no combinational path from any input to any output.

## Structure
- Package `icg_pkg` holds:
  - `icg_state_t` enum (OFF, WAKE, ON, HOLD).
  - Counter-width helper constants derived with `$clog2` of HOLD_CYCLES and WAKE_CYCLES, minimum width 1.
- Sub-module `icg_sat_counter` (parameter CNT_W; ports inc, clr, count) implements `gated_cnt`.
- The FSM and the wake and hold counters live in the top module.

## Test plan
- Reset, then idle for 20 cycles → `en`=0, `rdy`=0, `gated_cnt`=20; assert `rst` mid-count → `gated_cnt`=0 immediately.
- `act` pulse for 1 cycle at edge 5 (WAKE=1, HOLD=8) → `en` high after edge 5, `rdy` high after edge 6, `en` low after edge 14.
- `act` re-pulsed at the final HOLD cycle → `en` continuous with no gap; the new hold window is counted from the last `act`.
- `force_on` held for 50 cycles with `act`=0 → `en`=1 throughout and `gated_cnt` unchanged.
- CNT_W=4 and 20 idle cycles → `gated_cnt` saturates at 15; `cnt_clr` on the same cycle as an increment → 0.
- HOLD_CYCLES=0 and WAKE_CYCLES=0 → `en` and `rdy` rise 1 edge after `act`, and both fall 1 edge after `act` drops.
